// File: rtl/card_dealer.sv
// Two-card dealer drawing without replacement from a tracked 52-card deck.
// One card is revealed per clk_sec tick; game control sequences rounds via busy/done/deck_low.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter bit          RANDOM    = 1'b1
) (
    input  logic       clk_sec,
    input  logic       rst,
    input  logic       deal_req,
    input  logic       shuffle_req,
    output logic [5:0] card1,
    output logic [5:0] card2,
    output logic       busy,
    output logic       done,
    output logic       deck_low,
    output logic [5:0] cards_left
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DEAL1 = 2'd1;
    localparam logic [1:0] ST_DEAL2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [1:0]   state;
    logic [51:0]  used;
    logic [15:0]  lfsr;
    logic [15:0]  lfsr_next;
    logic         deal_q;
    logic         shuffle_q;
    logic         deal_rise;
    logic         shuffle_rise;

    logic [5:0]   cand_raw;
    logic [5:0]   cand;
    logic [103:0] used_dbl;
    logic [51:0]  used_rot;
    logic [5:0]   offset;
    logic         draw_ok;
    logic [6:0]   idx_sum;
    logic [5:0]   draw_idx;
    logic [1:0]   suit;
    logic [5:0]   suit_base;
    logic [3:0]   rank;
    logic [5:0]   draw_code;
    logic [51:0]  draw_onehot;

    assign deal_rise    = deal_req & ~deal_q;
    assign shuffle_rise = shuffle_req & ~shuffle_q;

    // Galois LFSR, shift right, feedback mask applied when the bit shifted out is 1.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

    assign cand_raw = RANDOM ? lfsr[5:0] : 6'd0;
    assign cand     = (cand_raw >= 6'd52) ? cand_raw - 6'd52 : cand_raw;

    // Rotating the used mask so bit 0 is deck position cand turns the circular
    // search into a plain lowest-zero priority encode.
    assign used_dbl = {used, used} >> cand;
    assign used_rot = used_dbl[51:0];

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        offset  = 6'd0;
        draw_ok = 1'b0;
        for (int k = 51; k >= 0; k--) begin
            if (!used_rot[k]) begin
                offset  = 6'(k);
                draw_ok = 1'b1;
            end
        end
    end

    assign idx_sum  = {1'b0, cand} + {1'b0, offset};
    assign draw_idx = (idx_sum >= 7'd52) ? 6'(idx_sum - 7'd52) : idx_sum[5:0];

    always_comb begin
        suit      = 2'd3;
        suit_base = 6'd39;
        if (draw_idx < 6'd13) begin
            suit      = 2'd0;
            suit_base = 6'd0;
        end else if (draw_idx < 6'd26) begin
            suit      = 2'd1;
            suit_base = 6'd13;
        end else if (draw_idx < 6'd39) begin
            suit      = 2'd2;
            suit_base = 6'd26;
        end
    end

    assign rank        = 4'(draw_idx - suit_base + 6'd1);
    assign draw_code   = {suit, rank};
    assign draw_onehot = 52'd1 << draw_idx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the used mask is real deck state, not scratch storage, so it is
    // cleared by rst; a reset mid-deal thereby returns any partly dealt card.
    always_ff @(posedge clk_sec or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            used       <= '0;
            lfsr       <= LFSR_SEED;
            deal_q     <= 1'b0;
            shuffle_q  <= 1'b0;
            card1      <= 6'd0;
            card2      <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            deck_low   <= 1'b0;
            cards_left <= 6'd52;
        end else begin
            lfsr      <= lfsr_next;
            deal_q    <= deal_req;
            shuffle_q <= shuffle_req;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (shuffle_rise) begin
                        used       <= '0;
                        cards_left <= 6'd52;
                        card1      <= 6'd0;
                        card2      <= 6'd0;
                        done       <= 1'b0;
                        deck_low   <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (deal_rise) begin
                        if (cards_left >= 6'd2) begin
                            card1    <= 6'd0;
                            card2    <= 6'd0;
                            done     <= 1'b0;
                            deck_low <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ST_DEAL1;
                        end else begin
                            deck_low <= 1'b1;
                        end
                    end
                end

                ST_DEAL1: begin
                    if (draw_ok) begin
                        card1      <= draw_code;
                        used       <= used | draw_onehot;
                        cards_left <= cards_left - 6'd1;
                    end
                    state <= ST_DEAL2;
                end

                ST_DEAL2: begin
                    if (draw_ok) begin
                        card2      <= draw_code;
                        used       <= used | draw_onehot;
                        cards_left <= cards_left - 6'd1;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a sequential-deal instance and an LFSR-driven instance share stimulus;
// the random one is checked against a deck model built from the draw rules.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk_sec = 1'b0;
    logic       rst = 1'b1;
    logic       deal_req = 1'b0;
    logic       shuffle_req = 1'b0;

    logic [5:0] s_card1, s_card2, s_left;
    logic       s_busy, s_done, s_low;
    logic [5:0] r_card1, r_card2, r_left;
    logic       r_busy, r_done, r_low;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left;
    int          seen[64];

    card_dealer #(.LFSR_SEED(SEED), .RANDOM(1'b0)) dut_seq (
        .clk_sec(clk_sec), .rst(rst), .deal_req(deal_req), .shuffle_req(shuffle_req),
        .card1(s_card1), .card2(s_card2), .busy(s_busy), .done(s_done),
        .deck_low(s_low), .cards_left(s_left)
    );

    card_dealer #(.LFSR_SEED(SEED), .RANDOM(1'b1)) dut_rnd (
        .clk_sec(clk_sec), .rst(rst), .deal_req(deal_req), .shuffle_req(shuffle_req),
        .card1(r_card1), .card2(r_card2), .busy(r_busy), .done(r_done),
        .deck_low(r_low), .cards_left(r_left)
    );

    always #5 clk_sec = ~clk_sec;

    // Reference random source: free-running from reset, one step per tick.
    always @(posedge clk_sec or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [5:0] code_of(input int k);
        return 6'((k / 13) * 16 + (k % 13) + 1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
        m_left = 52;
    endtask

    // Deck model: start at the LFSR-chosen position, walk forward circularly to the first card still in the deck.
    function automatic logic [5:0] model_draw(input logic [15:0] l);
        int c;
        c = int'(l[5:0]);
        if (c >= 52) c = c - 52;
        for (int i = 0; i < 52; i++) begin
            int k;
            k = (c + i) % 52;
            if (!m_used[k]) begin
                m_used[k] = 1'b1;
                m_left--;
                return code_of(k);
            end
        end
        return 6'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_sec);
        rst = 1'b0;
        model_clear();
    endtask

    // One deal request; returns the reference LFSR values in effect for the two draw edges.
    task automatic run_deal(output logic [15:0] l1, output logic [15:0] l2);
        @(negedge clk_sec) deal_req = 1'b1;
        @(negedge clk_sec) begin deal_req = 1'b0; l1 = m_lfsr; end
        @(negedge clk_sec) l2 = m_lfsr;
        @(negedge clk_sec);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({s_card1, s_card2} !== 12'd0) begin n_fail++; $display("FAIL reset_cards_seq: got %h %h want 00 00", s_card1, s_card2); end
        n_checks++; if ({s_busy, s_done, s_low} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_seq: got %b want 000", {s_busy, s_done, s_low}); end
        n_checks++; if (s_left !== 6'd52) begin n_fail++; $display("FAIL reset_left_seq: got %0d want 52", s_left); end
        n_checks++; if ({r_card1, r_card2} !== 12'd0) begin n_fail++; $display("FAIL reset_cards_rnd: got %h %h want 00 00", r_card1, r_card2); end
        n_checks++; if ({r_busy, r_done, r_low} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_rnd: got %b want 000", {r_busy, r_done, r_low}); end
        n_checks++; if (r_left !== 6'd52) begin n_fail++; $display("FAIL reset_left_rnd: got %0d want 52", r_left); end
    endtask

    task automatic test_first_deal();
        logic [15:0] l1, l2;
        logic [5:0]  e1, e2;
        for (int i = 0; i < 64; i++) seen[i] = 0;
        @(negedge clk_sec) begin
            deal_req = 1'b1;
            n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_before: got %b want 0", s_busy); end
        end
        @(negedge clk_sec) begin
            deal_req = 1'b0; l1 = m_lfsr;
            n_checks++; if ({s_busy, s_done, s_card1} !== {2'b10, 6'd0}) begin n_fail++; $display("FAIL first_deal1_entry: got busy=%b done=%b card1=%h want 1 0 00", s_busy, s_done, s_card1); end
        end
        @(negedge clk_sec) begin
            l2 = m_lfsr;
            n_checks++; if (s_card1 !== 6'h01) begin n_fail++; $display("FAIL first_card1: got %h want 01", s_card1); end
            n_checks++; if ({s_busy, s_done, s_card2} !== {2'b10, 6'd0}) begin n_fail++; $display("FAIL first_mid: got busy=%b done=%b card2=%h want 1 0 00", s_busy, s_done, s_card2); end
        end
        @(negedge clk_sec) begin
            n_checks++; if (s_card2 !== 6'h02) begin n_fail++; $display("FAIL first_card2: got %h want 02", s_card2); end
            n_checks++; if ({s_busy, s_done} !== 2'b01) begin n_fail++; $display("FAIL first_done: got busy=%b done=%b want 0 1", s_busy, s_done); end
            n_checks++; if (s_left !== 6'd50) begin n_fail++; $display("FAIL first_left: got %0d want 50", s_left); end
        end
        e1 = model_draw(l1);
        e2 = model_draw(l2);
        n_checks++; if ({r_card1, r_card2} !== {e1, e2}) begin n_fail++; $display("FAIL first_rnd_cards: got %h %h want %h %h", r_card1, r_card2, e1, e2); end
        n_checks++; if (r_left !== 6'(m_left)) begin n_fail++; $display("FAIL first_rnd_left: got %0d want %0d", r_left, m_left); end
        seen[r_card1]++;
        seen[r_card2]++;
    endtask

    task automatic test_full_deck();
        logic [15:0] l1, l2;
        logic [5:0]  e1, e2, keep1, keep2;
        int          good;
        for (int d = 1; d < 26; d++) begin
            run_deal(l1, l2);
            e1 = model_draw(l1);
            e2 = model_draw(l2);
            n_checks++; if ({s_card1, s_card2} !== {code_of(2 * d), code_of(2 * d + 1)}) begin n_fail++; $display("FAIL seq_deal_%0d: got %h %h want %h %h", d + 1, s_card1, s_card2, code_of(2 * d), code_of(2 * d + 1)); end
            n_checks++; if ({r_card1, r_card2} !== {e1, e2}) begin n_fail++; $display("FAIL rnd_deal_%0d: got %h %h want %h %h", d + 1, r_card1, r_card2, e1, e2); end
            seen[r_card1]++;
            seen[r_card2]++;
        end
        n_checks++; if ({s_card1, s_card2} !== {6'h3C, 6'h3D}) begin n_fail++; $display("FAIL last_deal_cards: got %h %h want 3c 3d", s_card1, s_card2); end
        n_checks++; if ({s_left, r_left} !== 12'd0) begin n_fail++; $display("FAIL empty_left: got %0d %0d want 0 0", s_left, r_left); end
        good = 0;
        for (int c = 0; c < 64; c++)
            if (seen[c] == 1 && (c % 16) >= 1 && (c % 16) <= 13) good++;
        n_checks++; if (good !== 52) begin n_fail++; $display("FAIL rnd_distinct: got %0d distinct valid codes want 52", good); end

        keep1 = r_card1;
        keep2 = r_card2;
        run_deal(l1, l2);
        n_checks++; if ({s_low, s_done, s_busy} !== 3'b110) begin n_fail++; $display("FAIL refused_flags: got low=%b done=%b busy=%b want 1 1 0", s_low, s_done, s_busy); end
        n_checks++; if ({s_card1, s_card2} !== {6'h3C, 6'h3D}) begin n_fail++; $display("FAIL refused_cards_seq: got %h %h want 3c 3d", s_card1, s_card2); end
        n_checks++; if ({r_low, r_card1, r_card2} !== {1'b1, keep1, keep2}) begin n_fail++; $display("FAIL refused_rnd: got low=%b %h %h want 1 %h %h", r_low, r_card1, r_card2, keep1, keep2); end
    endtask

    task automatic test_deal_shuffle_same();
        @(negedge clk_sec) begin deal_req = 1'b1; shuffle_req = 1'b1; end
        @(negedge clk_sec) begin
            n_checks++; if ({s_card1, s_card2, s_left} !== {12'd0, 6'd52}) begin n_fail++; $display("FAIL shuffle_seq: got %h %h left=%0d want 00 00 52", s_card1, s_card2, s_left); end
            n_checks++; if ({s_busy, s_done, s_low} !== 3'b000) begin n_fail++; $display("FAIL shuffle_flags: got %b want 000", {s_busy, s_done, s_low}); end
            n_checks++; if ({r_card1, r_card2, r_left} !== {12'd0, 6'd52}) begin n_fail++; $display("FAIL shuffle_rnd: got %h %h left=%0d want 00 00 52", r_card1, r_card2, r_left); end
        end
        @(negedge clk_sec) begin
            n_checks++; if ({s_busy, s_done, s_left} !== {2'b00, 6'd52}) begin n_fail++; $display("FAIL shuffle_no_deal: got busy=%b done=%b left=%0d want 0 0 52", s_busy, s_done, s_left); end
            deal_req = 1'b0;
            shuffle_req = 1'b0;
        end
        model_clear();
    endtask

    task automatic test_ignore_during_deal();
        logic [15:0] l1, l2;
        logic [5:0]  e1, e2;
        @(negedge clk_sec) deal_req = 1'b1;
        @(negedge clk_sec) begin deal_req = 1'b0; shuffle_req = 1'b1; l1 = m_lfsr; end
        @(negedge clk_sec) begin deal_req = 1'b1; l2 = m_lfsr; end
        @(negedge clk_sec);
        e1 = model_draw(l1);
        e2 = model_draw(l2);
        n_checks++; if ({s_card1, s_card2, s_left} !== {6'h01, 6'h02, 6'd50}) begin n_fail++; $display("FAIL ignore_seq: got %h %h left=%0d want 01 02 50", s_card1, s_card2, s_left); end
        n_checks++; if ({r_card1, r_card2} !== {e1, e2}) begin n_fail++; $display("FAIL ignore_rnd: got %h %h want %h %h", r_card1, r_card2, e1, e2); end
        repeat (3) @(negedge clk_sec);
        n_checks++; if ({s_busy, s_done, s_left, s_card1} !== {2'b01, 6'd50, 6'h01}) begin n_fail++; $display("FAIL ignore_single: got busy=%b done=%b left=%0d card1=%h want 0 1 50 01", s_busy, s_done, s_left, s_card1); end
        n_checks++; if (r_left !== 6'(m_left)) begin n_fail++; $display("FAIL ignore_rnd_left: got %0d want %0d", r_left, m_left); end
        deal_req = 1'b0;
        shuffle_req = 1'b0;
    endtask

    task automatic test_rst_mid_deal();
        logic [15:0] l1, l2;
        logic [5:0]  e1, e2;
        @(negedge clk_sec) deal_req = 1'b1;
        @(negedge clk_sec) deal_req = 1'b0;
        @(negedge clk_sec);
        n_checks++; if ({s_card1, s_busy} !== {6'h03, 1'b1}) begin n_fail++; $display("FAIL pre_rst: got card1=%h busy=%b want 03 1", s_card1, s_busy); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({s_card1, s_card2, s_busy, s_done, s_low, s_left} !== {12'd0, 3'b000, 6'd52}) begin n_fail++; $display("FAIL async_rst_seq: got %h %h %b%b%b left=%0d want 00 00 000 52", s_card1, s_card2, s_busy, s_done, s_low, s_left); end
        n_checks++; if ({r_card1, r_card2, r_busy, r_done, r_low, r_left} !== {12'd0, 3'b000, 6'd52}) begin n_fail++; $display("FAIL async_rst_rnd: got %h %h %b%b%b left=%0d want 00 00 000 52", r_card1, r_card2, r_busy, r_done, r_low, r_left); end
        #1 rst = 1'b0;
        model_clear();
        run_deal(l1, l2);
        e1 = model_draw(l1);
        e2 = model_draw(l2);
        n_checks++; if ({s_card1, s_card2, s_left} !== {6'h01, 6'h02, 6'd50}) begin n_fail++; $display("FAIL post_rst_seq: got %h %h left=%0d want 01 02 50", s_card1, s_card2, s_left); end
        n_checks++; if ({r_card1, r_card2} !== {e1, e2}) begin n_fail++; $display("FAIL post_rst_rnd: got %h %h want %h %h", r_card1, r_card2, e1, e2); end
    endtask

    initial begin
        test_reset();
        test_first_deal();
        test_full_deck();
        test_deal_shuffle_same();
        test_ignore_during_deal();
        test_rst_mid_deal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
